// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states,
// request source encoding and the auto-requester LFSR definition.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_SHOW = 2'b10
  } seq_state_e;

  typedef enum logic {
    SRC_MAN  = 1'b0,
    SRC_AUTO = 1'b1
  } src_e;

  localparam int                LFSR_W    = 6;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 6'b000001;

  // One step of the auto-requester LFSR: shift left, feed back bit5 ^ bit4.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[4:0], s[5] ^ s[4]};
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_alu2.sv
// Purely combinational 2-bit ALU with a 3-bit result.
// AND/OR are zero-extended, ADD is the full 3-bit sum, SUB returns
// {borrow, difference mod 4}.
module alu2
  import alu_seq_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] op,
  output logic [2:0] y
);

  logic [1:0] diff;

  assign diff = a - b;

  // Select the result for the requested opcode.
  always_comb begin
    y = 3'b000;
    case (op)
      OP_AND:  y = {1'b0, a & b};
      OP_OR:   y = {1'b0, a | b};
      OP_ADD:  y = {1'b0, a} + {1'b0, b};
      OP_SUB:  y = {a < b, diff};
      default: y = 3'b000;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer/arbiter for the shared 2-bit ALU feeding the display path.
// Grants one request at a time (manual switches or the LFSR auto requester),
// executes it on a single alu2 and presents the result for DWELL cycles.
// Handshake: man_req is a level held by the requester; man_ack is a
// one-cycle pulse after the granting edge, and the requester drops man_req
// on seeing it. auto_en is a level that is always pending while high.
// ena low freezes every register, including a pending man_ack pulse.
// Build option: define ALU_SEQ_MAN_PRIO_EN for strict manual priority
// instead of round-robin arbitration.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DWELL   = 100,
  parameter int DWELL_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       man_req,
  input  logic [1:0] man_a,
  input  logic [1:0] man_b,
  input  logic [1:0] man_op,
  output logic       man_ack,
  input  logic       auto_en,
  output logic [2:0] res,
  output logic       res_src,
  output logic       res_valid,
  output logic       busy,
  output logic [1:0] dbg_state
);

  if (DWELL < 1) begin : g_bad_dwell
    $error("alu_seq_ctrl: DWELL must be at least 1");
  end
  if (DWELL > (2 ** DWELL_W)) begin : g_bad_dwell_w
    $error("alu_seq_ctrl: DWELL_W too narrow for DWELL");
  end

  seq_state_e        state;
  seq_state_e        state_next;
  logic [LFSR_W-1:0] lfsr;
  logic [DWELL_W-1:0] cnt;
  logic [1:0]        opnd_a;
  logic [1:0]        opnd_b;
  logic [1:0]        opnd_op;
  src_e              opnd_src;
  logic [2:0]        alu_y;
  logic              grant_man;
  logic              grant_auto;

`ifndef ALU_SEQ_MAN_PRIO_EN
  src_e              last_grant;
`endif

  alu2 u_alu2 (
    .a  (opnd_a),
    .b  (opnd_b),
    .op (opnd_op),
    .y  (alu_y)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ena) begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> EXEC on a grant, EXEC -> SHOW, SHOW -> IDLE when the dwell expires.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_man || grant_auto) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_SHOW;
      ST_SHOW: if (cnt == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Arbitration strobes: only IDLE grants; a sole requester always wins.
  always_comb begin
    grant_man  = 1'b0;
    grant_auto = 1'b0;
    if (state == ST_IDLE) begin
`ifdef ALU_SEQ_MAN_PRIO_EN
      grant_man  = man_req;
      grant_auto = auto_en && !man_req;
`else
      if (man_req && auto_en) begin
        grant_man  = (last_grant == SRC_AUTO);
        grant_auto = (last_grant == SRC_MAN);
      end else begin
        grant_man  = man_req;
        grant_auto = auto_en;
      end
`endif
    end
  end

`ifndef ALU_SEQ_MAN_PRIO_EN
  // Round-robin memory: remembers who won the last grant; first tie goes to manual.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_AUTO;
    end else if (ena) begin
      if (grant_man)       last_grant <= SRC_MAN;
      else if (grant_auto) last_grant <= SRC_AUTO;
    end
  end
`endif

  // Grant side: ack pulse, operand capture and LFSR advance on auto grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      man_ack  <= 1'b0;
      lfsr     <= LFSR_SEED;
      opnd_a   <= 2'b00;
      opnd_b   <= 2'b00;
      opnd_op  <= 2'b00;
      opnd_src <= SRC_MAN;
    end else if (ena) begin
      man_ack <= grant_man;
      if (grant_man) begin
        opnd_a   <= man_a;
        opnd_b   <= man_b;
        opnd_op  <= man_op;
        opnd_src <= SRC_MAN;
      end else if (grant_auto) begin
        opnd_a   <= lfsr[1:0];
        opnd_b   <= lfsr[3:2];
        opnd_op  <= lfsr[5:4];
        opnd_src <= SRC_AUTO;
        lfsr     <= lfsr_next(lfsr);
      end
    end
  end

  // Result side: register the ALU output in EXEC and time the dwell in SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= 3'b000;
      res_src   <= 1'b0;
      res_valid <= 1'b0;
      cnt       <= '0;
    end else if (ena) begin
      case (state)
        ST_EXEC: begin
          res       <= alu_y;
          res_src   <= opnd_src;
          res_valid <= 1'b1;
          cnt       <= DWELL_W'(DWELL - 1);
        end
        ST_SHOW: begin
          if (cnt == '0) res_valid <= 1'b0;
          else           cnt       <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer and arbiter for the shared 2-bit ALU datapath feeding the 7-segment display path. It accepts operation requests from two requesters: the manual switch requester and an internal LFSR auto-requester. It grants one request at a time, executes the request on a single ALU instance, and holds the registered 3-bit result for a fixed dwell period so the display decoder can show it. It sits between the `ui_in` switch decode and the segment decoder, and replaces ad-hoc muxing of ALU and random sources.

## Interface
Parameters:
- `DWELL`, default 100: number of cycles a result is presented as valid; must be ≥1; elaboration error otherwise.
- `DWELL_W`, default 8: width of the dwell counter; must satisfy `DWELL ≤ 2^DWELL_W`.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ena`  in  1  global enable; when low, all state is frozen.
- `man_req`  in  1  manual request, level-sensitive; held until `man_ack`.
- `man_a`  in  2  manual operand A.
- `man_b`  in  2  manual operand B.
- `man_op`  in  2  manual opcode: 00 AND, 01 OR, 10 ADD, 11 SUB.
- `man_ack`  out  1  one-cycle pulse; manual request granted.
- `auto_en`  in  1  enables the auto requester; always pending while high.
- `res`  out  3  registered result.
- `res_src`  out  1  source of `res`: 0 manual, 1 auto.
- `res_valid`  out  1  high during the dwell period.
- `busy`  out  1  high while a request is in flight (EXEC or SHOW).

## Operation
- FSM states: IDLE, EXEC, SHOW.
- IDLE:
  - If any request is pending, grant one, latch its a/b/op/src into operand registers, and go to EXEC.
  - A manual grant sets `man_ack` high for the next cycle.
  - An auto grant advances the LFSR.
- EXEC:
  - `res` ← alu(latched operands); `res_src` ← latched src; `res_valid` ← 1.
  - Counter ← DWELL−1; go to SHOW.
- SHOW:
  - If counter==0, go to IDLE and clear `res_valid`.
  - Otherwise decrement the counter.
  - `res` holds until the next EXEC.
- ALU (3-bit result):
  - AND/OR: `{0, a op b}`.
  - ADD: `a+b`, zero-extended (0..6).
  - SUB: `{a<b, (a−b) mod 4}`; bit 2 is the borrow.
- Auto requester:
  - 6-bit LFSR, seed 6'b000001.
  - Next state = `{lfsr[4:0], lfsr[5]^lfsr[4]}`.
  - Operand mapping: a=lfsr[1:0], b=lfsr[3:2], op=lfsr[5:4].
  - The LFSR advances only on an auto grant.
- Arbitration:
  - Round-robin on a `last_grant` flag; reset value = auto, so the first tie goes to manual.
  - A sole requester is always granted.
- `man_req` deasserted before grant: the request is dropped, with no ack.
- `man_*` operands are sampled only on the granting edge; later changes have no effect.
- `auto_en` falling during EXEC/SHOW: the in-flight auto op completes normally.

## Timing
- Reset values: `res`=0, `res_src`=0, `res_valid`=0, `busy`=0, `man_ack`=0; state IDLE; counter 0; LFSR 6'b000001; `last_grant`=auto.
- Async assert of `rst_n` mid-operation takes effect immediately; the in-flight op is discarded. Deassertion is synchronised externally.
- Grant edge N → `man_ack` high and `busy` high in cycle N+1.
- `res` and `res_valid` update at edge N+1.
- `res_valid` stays high exactly DWELL cycles.
- `busy` stays high DWELL+1 cycles.
- Earliest next grant is at edge N+DWELL+2, giving a throughput of one op per DWELL+2 cycles.
- `ena`=0: no state, counter, or LFSR change. `man_ack`, if high, stays high until the next enabled edge. The dwell extends by the number of disabled cycles.

## Configuration
- `ALU_SEQ_MAN_PRIO_EN`:
  - Defined: strict priority; manual always wins a tie, and `last_grant` is unused.
  - Undefined: round-robin as above.

## Structure
- Package `alu_seq_pkg`:
  - opcode enum (AND/OR/ADD/SUB).
  - FSM state enum.
  - `LFSR_SEED`, LFSR width constant.
  - source encoding (MAN=0, AUTO=1).
- Sub-module `alu2`: purely combinational, inputs a[1:0], b[1:0], op[1:0]; output y[2:0]. Instantiated once.
- FSM, arbiter, LFSR and dwell counter live in `alu_seq_ctrl`.

## Test plan
- Reset: assert `rst_n`=0 mid-SHOW → same cycle `res`=0, `res_valid`=0, `busy`=0; after release, the first auto op uses seed operands.
- Manual ADD: DWELL=4, auto_en=0, a=3, b=3, op=10 → one `man_ack` pulse; `res`=3'b110, `res_src`=0; `res_valid` 4 cycles; `busy` 5 cycles.
- SUB borrow: a=1, b=2 → `res`=3'b111; a=2, b=1 → `res`=3'b001; OR a=2, b=1 → 3'b011.
- Tie: `man_req` and `auto_en` held high → `res_src` sequence 0,1,0,1; with `ALU_SEQ_MAN_PRIO_EN` → 0,0,0,0.
- Auto sequence: auto_en=1 only → first op a=01, b=00, AND → `res`=0; LFSR then 6'b000010; the following 8 results match a reference model.
- Enable stall: `ena`=0 for 10 cycles during SHOW with DWELL=4 → `res_valid` high for 14 clock cycles; counter and LFSR unchanged while stalled.
